// File: rtl/mux_n_to_1_pkg.sv
// mux_n_to_1_pkg: shared default input count and select-width helper
package mux_n_to_1_pkg;
  localparam int N_DEFAULT = 8;
  function automatic int sel_w(input int n);
    int w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/mux_n_to_1_tree.sv
// mux_n_to_1_tree: stateless binary tree of 2:1 muxes; leaves beyond N read as 0
module mux_n_to_1_tree #(
  parameter int N = 8,
  parameter int SEL_WIDTH = 3
) (
  input  logic [N-1:0]         d,
  input  logic [SEL_WIDTH-1:0] sel,
  output logic                 y
);
  localparam int L = 1 << SEL_WIDTH;
  // heap layout: node 1 is the root, node k has children 2k and 2k+1, leaves at L..2L-1
  logic node [1:2*L-1];
  for (genvar i = 0; i < L; i++) begin : g_leaf
    if (i < N) begin : g_d
      assign node[L+i] = d[i];
    end else begin : g_pad
      assign node[L+i] = 1'b0;
    end
  end
  for (genvar i = 1; i < L; i++) begin : g_node
    assign node[i] = sel[SEL_WIDTH-$clog2(i+1)] ? node[2*i+1] : node[2*i];
  end
  assign y = node[1];
endmodule

// File: rtl/mux_n_to_1.sv
// mux_n_to_1: registered N:1 bit select; define MUX_N_TO_1_SEL_CHECK_EN to flag out-of-range Sel
module mux_n_to_1
  import mux_n_to_1_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int SEL_WIDTH = sel_w(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         D,
  input  logic [SEL_WIDTH-1:0] Sel,
  input  logic                 in_valid,
  output logic                 Out,
  output logic                 out_valid,
  output logic                 sel_err
);
  logic y;
  mux_n_to_1_tree #(.N(N), .SEL_WIDTH(SEL_WIDTH)) u_tree (.d(D), .sel(Sel), .y(y));
  always_ff @(posedge clk) begin
    if (rst) begin
      Out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) Out <= y;
    end
  end
`ifdef MUX_N_TO_1_SEL_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) sel_err <= 1'b0;
    else if (in_valid) sel_err <= 32'(Sel) >= N;
  end
`else
  assign sel_err = 1'b0;
`endif
endmodule

// File: tb/tb_mux_n_to_1.sv
// tb_mux_n_to_1: scoreboard bench driving an N=8 and an N=5 instance in lockstep
module tb_mux_n_to_1;
  typedef struct packed {
    logic ov;
    logic o;
    logic e;
    logic o5;
    logic e5;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst, in_valid;
  logic [7:0] D;
  logic [2:0] Sel;
  logic       o8, ov8, e8, o5, ov5, e5;
  exp_t       q[$];
  exp_t       m = '0;
  int         n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  mux_n_to_1 dut8 (.clk(clk), .rst(rst), .D(D), .Sel(Sel), .in_valid(in_valid),
                   .Out(o8), .out_valid(ov8), .sel_err(e8));
  mux_n_to_1 #(.N(5), .SEL_WIDTH(3)) dut5 (.clk(clk), .rst(rst), .D(D[4:0]), .Sel(Sel),
                   .in_valid(in_valid), .Out(o5), .out_valid(ov5), .sel_err(e5));

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %b exp %b at %0t", tag, got, exp, $time);
  endtask

  task automatic step(input logic [7:0] d, input logic [2:0] s, input logic v, input logic r);
    exp_t x;
    D = d; Sel = s; in_valid = v; rst = r;
    if (r) m = '0;
    else begin
      m.ov = v;
      if (v) begin
        m.o  = d[s];
        m.o5 = (s < 5) ? d[s] : 1'b0;
`ifdef MUX_N_TO_1_SEL_CHECK_EN
        m.e5 = (s >= 5);
`else
        m.e5 = 1'b0;
`endif
        m.e = 1'b0;
      end
    end
    q.push_back(m);
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk("out_valid8", ov8, x.ov);
    chk("out8", o8, x.o);
    chk("sel_err8", e8, x.e);
    chk("out_valid5", ov5, x.ov);
    chk("out5", o5, x.o5);
    chk("sel_err5", e5, x.e5);
  endtask

  initial begin
    step(8'hff, 3'd3, 1'b1, 1'b1);
    step(8'h00, 3'd0, 1'b0, 1'b1);
    step(8'h01, 3'd0, 1'b1, 1'b0);
    step(8'h04, 3'd2, 1'b1, 1'b0);
    step(8'h20, 3'd5, 1'b1, 1'b0);
    step(8'h80, 3'd7, 1'b1, 1'b0);
    step(8'hfe, 3'd0, 1'b1, 1'b0);
    step(8'hff, 3'd0, 1'b0, 1'b0);
    step(8'hff, 3'd0, 1'b0, 1'b0);
    step(8'h1f, 3'd6, 1'b1, 1'b0);
    step(8'hff, 3'd1, 1'b0, 1'b0);
    step(8'h1f, 3'd4, 1'b1, 1'b0);
    step(8'hff, 3'd3, 1'b1, 1'b1);
    step(8'hff, 3'd3, 1'b1, 1'b0);
    for (int s = 0; s < 8; s++) begin
      step(8'(1 << s), 3'(s), 1'b1, 1'b0);
      step(~8'(1 << s), 3'(s), 1'b1, 1'b0);
    end
    for (int k = 0; k < 40; k++)
      step(8'($urandom), 3'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(9) == 0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mux_n_to_1.md
MUX_N_TO_1 -- requirements
Module: mux_n_to_1

Interface
REQ-001 SHALL have parameter N, default 8: number of data inputs, legal range 2..256.
REQ-002 SHALL have parameter SEL_WIDTH, default ceil(log2(N)): select width, minimum 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port D, input, N bits: data inputs, bit i is candidate i.
REQ-006 SHALL have port Sel, input, SEL_WIDTH bits: unsigned index of the selected D bit.
REQ-007 SHALL have port in_valid, input, 1 bit: D/Sel are sampled this cycle.
REQ-008 SHALL have port Out, output, 1 bit: registered selected bit.
REQ-009 SHALL have port out_valid, output, 1 bit: Out was updated by the previous cycle's sample.
REQ-010 SHALL have port sel_err, output, 1 bit: registered flag, sampled Sel was >= N.

Function
REQ-011 SHALL compute the combinational select as D[Sel] when Sel < N, else 0.
REQ-012 SHALL, on a clk edge with in_valid=1 and rst=0, load Out with the select result (latency 1 cycle).
REQ-013 SHALL, on a clk edge with in_valid=0 and rst=0, hold Out and sel_err unchanged.
REQ-014 SHALL set out_valid to in_valid registered one cycle (out_valid high for exactly the cycles after accepted samples).
REQ-015 SHALL have no backpressure: every in_valid=1 cycle is accepted; back-to-back samples produce back-to-back outputs.
REQ-016 SHALL, when Sel >= N on an accepted sample, drive Out=0 and sel_err=1; sel_err=0 for in-range accepted samples.
REQ-017 SHALL treat Sel as unsigned; X-free inputs are required, with no special X handling.
REQ-018 SHALL make Out depend on only one D bit per sample; changes to unselected D bits do not affect Out.
REQ-019 SHALL make all outputs fully determined one cycle after any accepted sample, with no combinational input-to-output path.

Reset
REQ-020 SHALL, on a clk edge with rst=1, force Out=0, out_valid=0 and sel_err=0, regardless of in_valid.
REQ-021 SHALL give rst priority over in_valid in the same cycle; a sample presented with rst=1 is discarded.
REQ-022 SHALL, after rst deasserts, accept the first sample on the first edge with in_valid=1.

Configuration
REQ-023 SHALL, with macro MUX_N_TO_1_SEL_CHECK_EN defined, implement the range detection of REQ-016 and drive sel_err as specified.
REQ-024 SHALL, without MUX_N_TO_1_SEL_CHECK_EN, tie sel_err to constant 0 and remove the comparator logic.
REQ-025 SHALL, in both configurations, drive Out=0 for out-of-range Sel.

Structure
REQ-026 SHALL place the default N constant and a select-width helper function (ceil-log2, minimum 1) in shared package mux_n_to_1_pkg.
REQ-027 SHALL implement the combinational selection in one sub-module, mux_n_to_1_tree: a binary tree of 2:1 stages of depth SEL_WIDTH, parameterised by N, with missing leaves padded to 0.
REQ-028 SHALL keep all registers (Out, out_valid, sel_err) in mux_n_to_1; the sub-module contains no state.

Verification
REQ-029 SHALL cover: N=8, D=00000001, Sel=000, in_valid=1 -> next cycle Out=1, out_valid=1, sel_err=0.
REQ-030 SHALL cover: N=8, back-to-back samples D=00000100/Sel=010, D=00100000/Sel=101, D=10000000/Sel=111 -> Out=1 on each following cycle.
REQ-031 SHALL cover: N=8, D=11111110, Sel=000 -> Out=0; then in_valid=0 while D changes to 11111111 -> Out stays 0 and out_valid=0.
REQ-032 SHALL cover: N=5, SEL_WIDTH=3, D=11111, Sel=110 -> Out=0, and sel_err=1 with MUX_N_TO_1_SEL_CHECK_EN defined, 0 without it.
REQ-033 SHALL cover: rst=1 together with in_valid=1, D=11111111, Sel=011 -> Out=0, out_valid=0, sel_err=0 after the edge.
REQ-034 SHALL cover: exhaustive sweep for N=8, every Sel 0..7 with one-hot and inverted-one-hot D -> Out equals D[Sel] one cycle later.
